// File: rtl/btn_event_pkg.sv
// Shared types for the button event decoder: FSM state encoding.
package btn_event_pkg;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PRESS = 2'd2,
    ST_HOLD  = 2'd3
  } st_t;

endpackage

// File: rtl/btn_event_if.sv
// Button level in, event pulses out. The button side (master) drives d_btn;
// btn_event (slave) drives the registered pulses, the held level and its FSM state.
// There is no valid/ready pair: every output is a one-cycle pulse or a level,
// and it is sampled on the clk edge that follows the cycle in which it is high.
// "release" is a language keyword, so that pulse is carried on release_pls.
interface btn_event_if;
  import btn_event_pkg::*;

  logic d_btn;
  logic press;
  logic release_pls;
  logic click;
  logic long_press;
  logic repeat_pls;
  logic held;
  st_t  state;

  modport master (
    output d_btn,
    input  press, release_pls, click, long_press, repeat_pls, held, state
  );

  modport slave (
    input  d_btn,
    output press, release_pls, click, long_press, repeat_pls, held, state
  );

endinterface

// File: rtl/btn_event_timer.sv
// Hold/repeat counter: clears to 0 unless incrementing, and flags when it
// equals the terminal count supplied by the FSM.
module btn_event_timer #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/btn_event.sv
// Decodes a debounced button level into press/release/click/long/repeat pulses.
// All outputs are registered and appear one clk after the sampled level change.
module btn_event
  import btn_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic        clk,
  input  logic        rst,
  btn_event_if.slave  bus
);

  if (LONG_CYCLES < 2 || LONG_CYCLES >= (1 << CNT_W)) begin : g_bad_long
    $error("btn_event: LONG_CYCLES out of range");
  end
  if (REPEAT_CYCLES < 1 || REPEAT_CYCLES >= (1 << CNT_W)) begin : g_bad_repeat
    $error("btn_event: REPEAT_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);

  st_t              state;
  logic             press_r, release_r, click_r, long_r, repeat_r, held_r;
  logic             tmr_inc;
  logic             tmr_tc;
  logic [CNT_W-1:0] tmr_tc_val;

  // The counter is cleared on the press edge, so it reads k-1 on the k-th
  // edge after press; comparing against N-1 fires exactly N edges later.
  always_comb begin
    tmr_inc    = 1'b0;
    tmr_tc_val = (state == ST_HOLD) ? REP_TC : LONG_TC;
    if ((state == ST_PRESS || state == ST_HOLD) && bus.d_btn && !tmr_tc) begin
      tmr_inc = 1'b1;
    end
  end

  btn_event_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (~tmr_inc),
    .inc    (tmr_inc),
    .tc_val (tmr_tc_val),
    .tc     (tmr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ARM;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      click_r   <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
      held_r    <= 1'b0;
    end else begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      click_r   <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
      case (state)
        ST_ARM: begin
          held_r <= 1'b0;
          if (!bus.d_btn) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.d_btn) begin
            state   <= ST_PRESS;
            press_r <= 1'b1;
            held_r  <= 1'b1;
          end
        end
        ST_PRESS: begin
          // Release is checked first so it wins over a coincident threshold.
          if (!bus.d_btn) begin
            state     <= ST_IDLE;
            release_r <= 1'b1;
            click_r   <= 1'b1;
            held_r    <= 1'b0;
          end else if (tmr_tc) begin
            state  <= ST_HOLD;
            long_r <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (!bus.d_btn) begin
            state     <= ST_IDLE;
            release_r <= 1'b1;
            held_r    <= 1'b0;
          end else if (tmr_tc) begin
            repeat_r <= 1'b1;
          end
        end
        default: state <= ST_ARM;
      endcase
    end
  end

  assign bus.press       = press_r;
  assign bus.release_pls = release_r;
  assign bus.click       = click_r;
  assign bus.long_press  = long_r;
  assign bus.repeat_pls  = repeat_r;
  assign bus.held        = held_r;
  assign bus.state       = state;

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event with LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4.
module tb_btn_event;
  import btn_event_pkg::*;

  localparam logic [5:0] P = 6'b100000;
  localparam logic [5:0] R = 6'b010000;
  localparam logic [5:0] C = 6'b001000;
  localparam logic [5:0] L = 6'b000100;
  localparam logic [5:0] Q = 6'b000010;
  localparam logic [5:0] H = 6'b000001;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  btn_event_if bif ();

  btn_event #(
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .CNT_W         (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bif.press, bif.release_pls, bif.click, bif.long_press, bif.repeat_pls, bif.held};
  endfunction

  // d_btn value sampled on edge e of test t (t=7: phase after the mid-hold reset)
  function automatic logic d_of(int t, int e);
    case (t)
      1: return (e < 22) || (e >= 30);
      2: return (e >= 10) && (e <= 12);
      3: return (e >= 10) && (e <= 29);
      4: return (e >= 10) && (e <= 17);
      5: return (e >= 10);
      6: return (e == 10) || (e == 11) || (e == 13) || (e == 14);
      7: return (e != 7);
      default: return 1'b0;
    endcase
  endfunction

  // Hand-derived outputs visible just after edge e
  function automatic logic [5:0] exp_of(int t, int e);
    case (t)
      1: begin
        if (e == 30) return P | H;
        if (e > 30)  return H;
        return 6'b0;
      end
      2: begin
        if (e == 10) return P | H;
        if (e == 11 || e == 12) return H;
        if (e == 13) return R | C;
        return 6'b0;
      end
      3: begin
        if (e == 10) return P | H;
        if (e == 18) return L | H;
        if (e == 22 || e == 26) return Q | H;
        if (e > 10 && e < 30) return H;
        if (e == 30) return R;
        return 6'b0;
      end
      4: begin
        if (e == 10) return P | H;
        if (e > 10 && e < 18) return H;
        if (e == 18) return R | C;
        return 6'b0;
      end
      5: begin
        if (e == 10) return P | H;
        if (e == 18) return L | H;
        if (e == 22) return Q | H;
        if (e > 10) return H;
        return 6'b0;
      end
      6: begin
        if (e == 10 || e == 13) return P | H;
        if (e == 11 || e == 14) return H;
        if (e == 12 || e == 15) return R | C;
        return 6'b0;
      end
      7: begin
        if (e == 8) return P | H;
        if (e > 8)  return H;
        return 6'b0;
      end
      default: return 6'b0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int t);
    rst       = 1'b1;
    bif.d_btn = d_of(t, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check($sformatf("t%0d_rst_outs", t), {2'b0, outs()}, 8'h00);
    check($sformatf("t%0d_rst_state", t), {6'b0, bif.state}, {6'b0, ST_ARM});
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts at a negedge; leaves the bench just after the last checked edge.
  task automatic run_edges(input int t, input int n_edges, output int n_press, output int n_rel);
    n_press = 0;
    n_rel   = 0;
    for (int e = 1; e <= n_edges; e++) begin
      bif.d_btn = d_of(t, e);
      @(posedge clk);
      #1;
      check($sformatf("t%0d_e%0d", t, e), {2'b0, outs()}, {2'b0, exp_of(t, e)});
      n_press += int'(bif.press);
      n_rel   += int'(bif.release_pls);
      if (t == 1 && e == 21) check("t1_arm_state", {6'b0, bif.state}, {6'b0, ST_ARM});
      if (t == 1 && e == 22) check("t1_idle_state", {6'b0, bif.state}, {6'b0, ST_IDLE});
      if (t == 3 && e == 18) check("t3_hold_state", {6'b0, bif.state}, {6'b0, ST_HOLD});
      if (e != n_edges) @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    int np, nr;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bif.d_btn = 1'b0;

    for (int t = 1; t <= 6; t++) begin
      do_reset(t);
      run_edges(t, (t == 5) ? 23 : 36, np, nr);
      if (t == 6) begin
        check("t6_press_count", 8'(np), 8'd2);
        check("t6_release_count", 8'(nr), 8'd2);
      end
      if (t == 5) begin
        // reset lands between edges 23 and 24, mid-hold
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_outs", {2'b0, outs()}, 8'h00);
        check("t5_async_state", {6'b0, bif.state}, {6'b0, ST_ARM});
        @(posedge clk);
        #1;
        check("t5_no_release", {2'b0, outs()}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        run_edges(7, 10, np, nr);
        check("t7_press_count", 8'(np), 8'd1);
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sequence did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
